// File: rtl/mips_bus_pkg.sv
// Shared types for the Harvard-to-Avalon arbiter.
// Holds the arbiter state encoding and the priority modes.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INSTR_RD,
    DATA_RD,
    DATA_WR
  } arb_state_t;

  typedef enum logic {
    GNT_INSTR,
    GNT_DATA
  } grant_t;

  localparam int PRIO_DATA_FIRST  = 0;
  localparam int PRIO_ROUND_ROBIN = 1;

endpackage

// File: rtl/mips_instr_hold_reg.sv
// One-entry instruction hold register.
// Serves a repeated fetch without a bus access.
module mips_instr_hold_reg
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              wr_done,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hold_data
);

  logic [ADDR_W-1:0] hold_addr;
  logic              hold_valid;

  // A write to the held address makes the copy stale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_addr  <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else if (load) begin
      hold_addr  <= load_addr;
      hold_data  <= load_data;
      hold_valid <= 1'b1;
    end else if (wr_done && wr_addr == hold_addr) begin
      hold_valid <= 1'b0;
    end
  end

  assign hit = hold_valid && (lookup_addr == hold_addr);

endmodule

// File: rtl/mips_avalon_arbiter.sv
// Two-channel Harvard core to single Avalon-MM master arbiter.
// Data-first or round-robin priority, optional instruction hold.
module mips_avalon_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int PRIORITY   = 0,
  parameter int INSTR_HOLD = 1,
  localparam int BE_W      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_req,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic              instr_ready,
  output logic [DATA_W-1:0] instr_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [BE_W-1:0]   data_be,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ready,
  output logic [DATA_W-1:0] data_rdata,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata,
  output logic              read,
  output logic              write,
  output logic [BE_W-1:0]   byteenable,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writedata,
  output logic              busy
);

  arb_state_t state, state_nxt;
  grant_t     last_grant;

  logic i_elig, d_elig, i_bus;
  logic hold_match, hold_hit;
  logic gnt_i, gnt_d, done;
  logic [DATA_W-1:0] hold_data;

  localparam bit RR = (PRIORITY == PRIO_ROUND_ROBIN);

  // Ready high means this cycle completes the request; do not re-serve it.
  assign i_elig   = instr_req && !instr_ready;
  assign d_elig   = data_req && !data_ready;
  assign hold_hit = (state == IDLE) && i_elig && hold_match;
  assign i_bus    = i_elig && !hold_match;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    gnt_i     = 1'b0;
    gnt_d     = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_elig && (!i_bus || !RR || last_grant == GNT_INSTR))
          gnt_d = 1'b1;
        else if (i_bus)
          gnt_i = 1'b1;
        if (gnt_d)
          state_nxt = data_we ? DATA_WR : DATA_RD;
        else if (gnt_i)
          state_nxt = INSTR_RD;
      end
      default: begin
        if (!waitrequest) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_grant  <= GNT_INSTR;
      read        <= 1'b0;
      write       <= 1'b0;
      address     <= '0;
      byteenable  <= '0;
      writedata   <= '0;
      instr_ready <= 1'b0;
      data_ready  <= 1'b0;
      instr_rdata <= '0;
      data_rdata  <= '0;
    end else begin
      state       <= state_nxt;
      instr_ready <= 1'b0;
      data_ready  <= 1'b0;
      if (hold_hit) begin
        instr_ready <= 1'b1;
        instr_rdata <= hold_data;
      end
      if (gnt_d) begin
        address    <= data_addr;
        byteenable <= data_be;
        writedata  <= data_wdata;
        read       <= !data_we;
        write      <= data_we;
        last_grant <= GNT_DATA;
      end else if (gnt_i) begin
        address    <= instr_addr;
        byteenable <= '1;
        writedata  <= '0;
        read       <= 1'b1;
        write      <= 1'b0;
        last_grant <= GNT_INSTR;
      end
      if (done) begin
        read  <= 1'b0;
        write <= 1'b0;
        unique case (1'b1)
          state == INSTR_RD: begin
            instr_ready <= 1'b1;
            instr_rdata <= readdata;
          end
          state == DATA_RD: begin
            data_ready <= 1'b1;
            data_rdata <= readdata;
          end
          default: data_ready <= 1'b1;
        endcase
      end
    end
  end

  generate
    if (INSTR_HOLD != 0) begin : g_hold
      mips_instr_hold_reg #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
      ) u_hold (
        .clk        (clk),
        .reset      (reset),
        .load       (done && state == INSTR_RD),
        .load_addr  (address),
        .load_data  (readdata),
        .wr_done    (done && state == DATA_WR),
        .wr_addr    (address),
        .lookup_addr(instr_addr),
        .hit        (hold_match),
        .hold_data  (hold_data)
      );
    end else begin : g_nohold
      assign hold_match = 1'b0;
      assign hold_data  = '0;
    end
  endgenerate

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Directed bench: data-first instance (0) and round-robin instance (1).
module tb_mips_avalon_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset       [2];
  logic        instr_req   [2];
  logic [31:0] instr_addr  [2];
  logic        instr_ready [2];
  logic [31:0] instr_rdata [2];
  logic        data_req    [2];
  logic        data_we     [2];
  logic [3:0]  data_be     [2];
  logic [31:0] data_addr   [2];
  logic [31:0] data_wdata  [2];
  logic        data_ready  [2];
  logic [31:0] data_rdata  [2];
  logic        waitrequest [2];
  logic [31:0] readdata    [2];
  logic        read        [2];
  logic        write       [2];
  logic [3:0]  byteenable  [2];
  logic [31:0] address     [2];
  logic [31:0] writedata   [2];
  logic        busy        [2];

  int ws     [2];
  int cnt    [2];
  int rd_cyc [2];
  int wr_cyc [2];
  int ir_cnt [2];
  int dr_cnt [2];
  int bus_cnt[2];
  logic [31:0] order0[$];
  logic [31:0] order1[$];

  int n_tests = 0;
  int n_fail  = 0;

  mips_avalon_arbiter #(.PRIORITY(0), .INSTR_HOLD(1)) u_dut0 (
    .clk(clk), .reset(reset[0]),
    .instr_req(instr_req[0]), .instr_addr(instr_addr[0]),
    .instr_ready(instr_ready[0]), .instr_rdata(instr_rdata[0]),
    .data_req(data_req[0]), .data_we(data_we[0]), .data_be(data_be[0]),
    .data_addr(data_addr[0]), .data_wdata(data_wdata[0]),
    .data_ready(data_ready[0]), .data_rdata(data_rdata[0]),
    .waitrequest(waitrequest[0]), .readdata(readdata[0]),
    .read(read[0]), .write(write[0]), .byteenable(byteenable[0]),
    .address(address[0]), .writedata(writedata[0]), .busy(busy[0])
  );

  mips_avalon_arbiter #(.PRIORITY(1), .INSTR_HOLD(1)) u_dut1 (
    .clk(clk), .reset(reset[1]),
    .instr_req(instr_req[1]), .instr_addr(instr_addr[1]),
    .instr_ready(instr_ready[1]), .instr_rdata(instr_rdata[1]),
    .data_req(data_req[1]), .data_we(data_we[1]), .data_be(data_be[1]),
    .data_addr(data_addr[1]), .data_wdata(data_wdata[1]),
    .data_ready(data_ready[1]), .data_rdata(data_rdata[1]),
    .waitrequest(waitrequest[1]), .readdata(readdata[1]),
    .read(read[1]), .write(write[1]), .byteenable(byteenable[1]),
    .address(address[1]), .writedata(writedata[1]), .busy(busy[1])
  );

  // Slave: stall each transfer for ws cycles.
  always_comb begin
    for (int i = 0; i < 2; i++)
      waitrequest[i] = (read[i] || write[i]) && (cnt[i] < ws[i]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!(read[i] || write[i]) || !waitrequest[i]) cnt[i] <= 0;
      else cnt[i] <= cnt[i] + 1;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (read[i]) rd_cyc[i]++;
      if (write[i]) wr_cyc[i]++;
      if (instr_ready[i]) ir_cnt[i]++;
      if (data_ready[i]) dr_cnt[i]++;
      if ((read[i] || write[i]) && !waitrequest[i]) begin
        bus_cnt[i]++;
        if (i == 0) order0.push_back(address[i]);
        else order1.push_back(address[i]);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_fetch(input int i, input logic [31:0] a,
                          output int lat, output logic [3:0] be);
    lat = 99;
    be  = '0;
    @(posedge clk); #1;
    instr_req[i]  = 1'b1;
    instr_addr[i] = a;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (read[i]) be = byteenable[i];
      if (instr_ready[i]) begin
        lat = k;
        break;
      end
    end
    @(posedge clk); #1;
    instr_req[i] = 1'b0;
  endtask

  task automatic do_data(input int i, input logic we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat);
    lat = 99;
    @(posedge clk); #1;
    data_req[i]   = 1'b1;
    data_we[i]    = we;
    data_be[i]    = be;
    data_addr[i]  = a;
    data_wdata[i] = wd;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (data_ready[i]) begin
        lat = k;
        break;
      end
    end
    @(posedge clk); #1;
    data_req[i] = 1'b0;
  endtask

  task automatic do_pair(input int i, input logic [31:0] ia,
                         input logic [31:0] da);
    logic idone, ddone;
    idone = 1'b0;
    ddone = 1'b0;
    @(posedge clk); #1;
    instr_req[i]  = 1'b1;
    instr_addr[i] = ia;
    data_req[i]   = 1'b1;
    data_we[i]    = 1'b0;
    data_be[i]    = 4'hF;
    data_addr[i]  = da;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (instr_ready[i]) idone = 1'b1;
      if (data_ready[i]) ddone = 1'b1;
      if (idone && ddone) break;
      @(posedge clk); #1;
      if (idone) instr_req[i] = 1'b0;
      if (ddone) data_req[i] = 1'b0;
    end
    if (!(idone && ddone)) chk("pair_timeout", {idone, ddone}, 2'b11);
    @(posedge clk); #1;
    instr_req[i] = 1'b0;
    data_req[i]  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, r0, w0, b0, i0;
    logic [3:0] be;
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b0;
      instr_req[i] = 1'b0;
      instr_addr[i] = '0;
      data_req[i] = 1'b0;
      data_we[i] = 1'b0;
      data_be[i] = '0;
      data_addr[i] = '0;
      data_wdata[i] = '0;
      readdata[i] = '0;
      ws[i] = 0;
      cnt[i] = 0;
      rd_cyc[i] = 0;
      wr_cyc[i] = 0;
      ir_cnt[i] = 0;
      dr_cnt[i] = 0;
      bus_cnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_rw", {read[i], write[i]}, 2'b00);
      chk("rst_addr", address[i], 32'h0);
      chk("rst_be_wd", {byteenable[i], writedata[i]}, 36'h0);
      chk("rst_ready", {instr_ready[i], data_ready[i], busy[i]}, 3'b000);
      chk("rst_rdata", {instr_rdata[i], data_rdata[i]}, 64'h0);
    end
    @(posedge clk); #1;
    reset[0] = 1'b1;
    reset[1] = 1'b1;

    // zero-wait fetch
    readdata[0] = 32'h24020005;
    r0 = rd_cyc[0]; b0 = bus_cnt[0]; i0 = ir_cnt[0];
    do_fetch(0, 32'hBFC00000, lat, be);
    chk("fetch_lat", lat, 2);
    chk("fetch_rdata", instr_rdata[0], 32'h24020005);
    chk("fetch_be", be, 4'hF);
    repeat (3) @(posedge clk);
    chk("fetch_rdcyc", rd_cyc[0] - r0, 1);
    chk("fetch_bus_once", bus_cnt[0] - b0, 1);
    chk("fetch_ready_once", ir_cnt[0] - i0, 1);

    // write with three stall cycles
    ws[0] = 3;
    w0 = wr_cyc[0]; i0 = dr_cnt[0];
    @(posedge clk); #1;
    data_req[0] = 1'b1;
    data_we[0] = 1'b1;
    data_be[0] = 4'h3;
    data_addr[0] = 32'h00001000;
    data_wdata[0] = 32'hDEADBEEF;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("wr_strobe", {write[k > 99 ? 1 : 0], read[0]}, 2'b10);
      chk("wr_addr", address[0], 32'h00001000);
      chk("wr_data", writedata[0], 32'hDEADBEEF);
      chk("wr_be", byteenable[0], 4'h3);
      chk("wr_noready", data_ready[0], 1'b0);
    end
    @(negedge clk);
    chk("wr_done", {data_ready[0], write[0]}, 2'b10);
    @(posedge clk); #1;
    data_req[0] = 1'b0;
    ws[0] = 0;
    repeat (2) @(posedge clk);
    chk("wr_cycles", wr_cyc[0] - w0, 4);
    chk("wr_ready_once", dr_cnt[0] - i0, 1);

    // refetch from hold register
    readdata[0] = 32'h11111111;
    r0 = rd_cyc[0];
    do_fetch(0, 32'hBFC00000, lat, be);
    chk("hold_lat", lat, 1);
    chk("hold_rdata", instr_rdata[0], 32'h24020005);
    chk("hold_nobus", rd_cyc[0] - r0, 0);

    // write to the held address invalidates it
    do_data(0, 1'b1, 4'hF, 32'hBFC00000, 32'h0, lat);
    chk("inv_wr_lat", lat, 2);
    r0 = rd_cyc[0];
    do_fetch(0, 32'hBFC00000, lat, be);
    chk("inv_lat", lat, 2);
    chk("inv_rdata", instr_rdata[0], 32'h11111111);
    chk("inv_bus", rd_cyc[0] - r0, 1);

    // data-first priority
    readdata[0] = 32'hCAFEF00D;
    order0.delete();
    do_pair(0, 32'h00000100, 32'h00000200);
    chk("p0_count", order0.size(), 2);
    if (order0.size() == 2) begin
      chk("p0_first", order0[0], 32'h00000200);
      chk("p0_second", order0[1], 32'h00000100);
    end
    chk("p0_drdata", data_rdata[0], 32'hCAFEF00D);
    chk("p0_irdata", instr_rdata[0], 32'hCAFEF00D);

    // round-robin over four pairs
    readdata[1] = 32'h0000ABCD;
    order1.delete();
    for (int p = 0; p < 4; p++)
      do_pair(1, 32'h400 + 32'(p * 4), 32'h800 + 32'(p * 4));
    chk("rr_count", order1.size(), 8);
    if (order1.size() == 8) begin
      for (int p = 0; p < 4; p++) begin
        chk("rr_data", order1[2 * p], 32'h800 + 32'(p * 4));
        chk("rr_instr", order1[2 * p + 1], 32'h400 + 32'(p * 4));
      end
    end

    // reset while stalled
    ws[0] = 5;
    i0 = ir_cnt[0];
    @(posedge clk); #1;
    instr_req[0] = 1'b1;
    instr_addr[0] = 32'h00000300;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_pre", {read[0], waitrequest[0]}, 2'b11);
    #1;
    reset[0] = 1'b0;
    #1;
    chk("rst_mid_read", {read[0], busy[0]}, 2'b00);
    instr_req[0] = 1'b0;
    repeat (2) @(posedge clk); #1;
    reset[0] = 1'b1;
    ws[0] = 0;
    repeat (3) @(posedge clk);
    chk("rst_mid_noready", ir_cnt[0] - i0, 0);
    r0 = rd_cyc[0];
    do_fetch(0, 32'h00000100, lat, be);
    chk("rst_refetch_lat", lat, 2);
    chk("rst_refetch_bus", rd_cyc[0] - r0, 1);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
